mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the 5-stage LoongArch pipeline, between EX and WB. It takes the EX payload and the
//  synchronous data-SRAM read word, aligns and extends load data, and selects the writeback value. It
//  passes the CSR/exception bundle through unchanged and provides forwarding and hazard information to ID.
//  It also holds load data across WB back-pressure and kills its instruction when WB flushes.
// PARAMETERS
//  EXC_W    96  exception bundle width {csr_num14,csr_we1,wmask32,wvalue32,ertn1,ex1,ecode6,esubcode9}
//  EXD_W    76  EX->MEM payload {ld_op5(b,h,w,bu,hu),res_from_mem1,rf_we1,rf_waddr5,alu_result32,pc32}
// PORTS
//  clk              in   1      clock, rising edge
//  resetn           in   1      reset, asynchronous, active-low
//  ex_to_mem_valid  in   1      EX holds a valid instruction
//  ex_to_mem_data   in   EXD_W  EX payload
//  ex_to_mem_excep  in   EXC_W  EX exception/CSR bundle
//  mem_allowin      out  1      MEM accepts the EX payload this cycle
//  data_sram_rdata  in   32     SRAM read word, valid only in the first cycle the instruction sits in MEM
//  wb_allowin       in   1      WB accepts this cycle
//  wb_flush         in   1      WB exception or ertn commit; kills MEM's content
//  mem_to_wb_valid  out  1      valid toward WB
//  mem_to_wb_data   out  70     {rf_we,rf_waddr5,final_result32,pc32}
//  mem_to_wb_excep  out  EXC_W  registered exception bundle, unchanged
//  mem_rf_zip       out  39     {res_from_mem&valid, rf_we&valid, rf_waddr5, final_result32} for ID
//  mem_ex           out  1      valid & (ex|ertn); EX uses it to suppress stores
//  mem_csr_blk      out  1      valid & (csr_we|ertn|ex); ID uses it as a CSR hazard stall
// BEHAVIOUR
//  - Reset values: mem_valid=0, payload/excep regs=0, rdata_buf=0, rdata_held=0. All outputs therefore
//    start at 0 and mem_allowin starts at 1.
//  - ready_go=1; mem_allowin = ~mem_valid | (ready_go & wb_allowin).
//  - mem_valid: if wb_flush -> 0; else if mem_allowin -> ex_to_mem_valid. wb_flush wins over a
//    simultaneous accept.
//  - Payload/excep regs load on ex_to_mem_valid & mem_allowin & ~wb_flush, with no other enable.
//  - Load-data holding:
//    - rdata_held: cleared on accept; set when mem_valid & ~rdata_held.
//    - rdata_buf: captures data_sram_rdata in that same cycle.
//    - rdata_sel = rdata_held ? rdata_buf : data_sram_rdata.
//    - Output must not change when WB stalls for N>=1 cycles and the SRAM bus changes.
//  - Alignment: off=alu_result[1:0].
//    - byte = rdata_sel[8*off+:8]; half = off[1] ? rdata_sel[31:16] : rdata_sel[15:0].
//    - ld_b/ld_h sign-extend; ld_bu/ld_hu zero-extend; ld_w returns the full word.
//    - Misaligned addresses are already trapped upstream; no check is done here.
//  - final_result = res_from_mem ? load_data : alu_result.
//  - mem_to_wb_valid = mem_valid & ready_go & ~wb_flush; it is combinationally 0 in the flush cycle.
//  - Back-to-back instructions flow at one per cycle when wb_allowin=1, with one-cycle MEM latency.
//  - Reset asserted mid-operation clears valid immediately and asynchronously. The first accept after
//    release behaves as a fresh entry.
// TESTING
//  1. ld.b, alu_result=0x1003, rdata=0x80FF1234 -> WB result 0xFFFFFF80, rf_we=1, pc passed through.
//  2. ld.hu, alu_result=0x2002, rdata=0x80017FFF -> 0x00008001; ld.h at same address -> 0xFFFF8001.
//  3. ld.w enters MEM with rdata=0xDEADBEEF. Hold wb_allowin=0 for 3 cycles while the bus changes to
//     0x0 -> result stays 0xDEADBEEF and mem_allowin=0 throughout.
//  4. Non-load add with alu_result=0x12345678 -> result 0x12345678, mem_rf_zip[38]=0, rf_we=1.
//  5. wb_flush=1 while mem_valid=1 and EX offers a new instruction -> mem_to_wb_valid=0 at once,
//     mem_valid=0 next cycle, new instruction dropped.
//  6. resetn=0 mid-stream -> mem_valid, mem_ex, mem_csr_blk all 0 before the next clock.
//     Excep bundle with ex=1 -> mem_ex=1, mem_csr_blk=1, bundle bit-identical at WB.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: LoongArch MEM stage - load alignment/extension, writeback select, load-data hold across WB stalls,
// CSR/exception pass-through and forwarding/hazard info for ID.
module mem_stage #(
  parameter int EXC_W = 96,
  parameter int EXD_W = 76
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_to_mem_valid,
  input  logic [EXD_W-1:0] ex_to_mem_data,
  input  logic [EXC_W-1:0] ex_to_mem_excep,
  output logic             mem_allowin,
  input  logic [31:0]      data_sram_rdata,
  input  logic             wb_allowin,
  input  logic             wb_flush,
  output logic             mem_to_wb_valid,
  output logic [69:0]      mem_to_wb_data,
  output logic [EXC_W-1:0] mem_to_wb_excep,
  output logic [38:0]      mem_rf_zip,
  output logic             mem_ex,
  output logic             mem_csr_blk
);
  logic             mem_valid_q, mem_valid_d;
  logic [EXD_W-1:0] data_q, data_d;
  logic [EXC_W-1:0] excep_q, excep_d;
  logic [31:0]      rdata_buf_q, rdata_buf_d;
  logic             rdata_held_q, rdata_held_d;
  logic             ready_go, accept, first_cycle;
  logic             ld_b, ld_h, ld_w, ld_bu, ld_hu, res_from_mem, rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      alu_result, pc, rdata_sel, load_data, final_result;
  logic [1:0]       off;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic             unused_ld_w;

  assign ready_go     = 1'b1;
  assign mem_allowin  = ~mem_valid_q | (ready_go & wb_allowin);
  assign accept       = ex_to_mem_valid & mem_allowin & ~wb_flush;
  assign first_cycle  = mem_valid_q & ~rdata_held_q;

  assign {ld_b, ld_h, ld_w, ld_bu, ld_hu, res_from_mem, rf_we, rf_waddr, alu_result, pc} = data_q;
  assign unused_ld_w = ld_w;

  // SRAM word is only valid in the first MEM cycle; afterwards the buffered copy is used
  assign rdata_sel    = rdata_held_q ? rdata_buf_q : data_sram_rdata;
  assign off          = alu_result[1:0];
  assign byte_v       = rdata_sel[{off, 3'b000} +: 8];
  assign half_v       = off[1] ? rdata_sel[31:16] : rdata_sel[15:0];
  assign load_data    = ld_b  ? {{24{byte_v[7]}}, byte_v} :
                        ld_bu ? {24'b0, byte_v} :
                        ld_h  ? {{16{half_v[15]}}, half_v} :
                        ld_hu ? {16'b0, half_v} : rdata_sel;
  assign final_result = res_from_mem ? load_data : alu_result;

  assign mem_to_wb_valid = mem_valid_q & ready_go & ~wb_flush;
  assign mem_to_wb_data  = {rf_we, rf_waddr, final_result, pc};
  assign mem_to_wb_excep = excep_q;
  assign mem_rf_zip      = {res_from_mem & mem_valid_q, rf_we & mem_valid_q, rf_waddr, final_result};
  assign mem_ex          = mem_valid_q & (excep_q[15] | excep_q[16]);
  assign mem_csr_blk     = mem_valid_q & (excep_q[81] | excep_q[16] | excep_q[15]);

  always_comb begin
    mem_valid_d  = wb_flush ? 1'b0 : mem_allowin ? ex_to_mem_valid : mem_valid_q;
    data_d       = accept ? ex_to_mem_data : data_q;
    excep_d      = accept ? ex_to_mem_excep : excep_q;
    rdata_held_d = accept ? 1'b0 : first_cycle ? 1'b1 : rdata_held_q;
    rdata_buf_d  = first_cycle ? data_sram_rdata : rdata_buf_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      data_q       <= '0;
      excep_q      <= '0;
      rdata_buf_q  <= '0;
      rdata_held_q <= 1'b0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      data_q       <= data_d;
      excep_q      <= excep_d;
      rdata_buf_q  <= rdata_buf_d;
      rdata_held_q <= rdata_held_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenario tasks plus a randomized run against a transaction-level MEM model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_to_mem_valid;
  logic [75:0] ex_to_mem_data;
  logic [95:0] ex_to_mem_excep;
  logic        mem_allowin;
  logic [31:0] data_sram_rdata;
  logic        wb_allowin;
  logic        wb_flush;
  logic        mem_to_wb_valid;
  logic [69:0] mem_to_wb_data;
  logic [95:0] mem_to_wb_excep;
  logic [38:0] mem_rf_zip;
  logic        mem_ex;
  logic        mem_csr_blk;
  int checks = 0;
  int errors = 0;

  localparam logic [4:0] LD_B = 5'b10000, LD_H = 5'b01000, LD_W = 5'b00100, LD_BU = 5'b00010, LD_HU = 5'b00001;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .ex_to_mem_valid(ex_to_mem_valid), .ex_to_mem_data(ex_to_mem_data),
    .ex_to_mem_excep(ex_to_mem_excep), .mem_allowin(mem_allowin), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .wb_flush(wb_flush), .mem_to_wb_valid(mem_to_wb_valid),
    .mem_to_wb_data(mem_to_wb_data), .mem_to_wb_excep(mem_to_wb_excep), .mem_rf_zip(mem_rf_zip),
    .mem_ex(mem_ex), .mem_csr_blk(mem_csr_blk)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] mk(input logic [4:0] op, input logic rfm, input logic we,
                                      input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] pc);
    return {op, rfm, we, wa, alu, pc};
  endfunction

  // Reference load result computed from the word and address with shifts and integer sign handling
  function automatic logic [31:0] ref_result(input logic [75:0] d, input logic [31:0] w);
    int unsigned off, b, h;
    off = d[33:32];
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    if (!d[70]) return d[63:32];
    if (d[75]) return (b >= 128) ? b - 256 : b;
    if (d[74]) return (h >= 32768) ? h - 65536 : h;
    if (d[72]) return b;
    if (d[71]) return h;
    return w;
  endfunction

  task automatic enter(input logic [75:0] d, input logic [95:0] x);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_data  = d;
    ex_to_mem_excep = x;
    @(posedge clk); #1;
    ex_to_mem_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0; ex_to_mem_valid = 0; ex_to_mem_data = '0; ex_to_mem_excep = '0;
    data_sram_rdata = 32'h5555AAAA; wb_allowin = 1; wb_flush = 0;
    @(negedge clk);
    checks++;
    if ({mem_to_wb_valid, mem_to_wb_data, mem_to_wb_excep, mem_rf_zip, mem_ex, mem_csr_blk} !== '0) begin
      errors++; $display("FAIL reset_outputs got wbv=%b data=%h zip=%h ex=%b blk=%b exp all 0",
                         mem_to_wb_valid, mem_to_wb_data, mem_rf_zip, mem_ex, mem_csr_blk);
    end
    checks++;
    if (mem_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b exp 1", mem_allowin); end
    @(posedge clk); #1; resetn = 1'b1;
  endtask

  task automatic test_ld_b;
    enter(mk(LD_B, 1, 1, 5'd4, 32'h1003, 32'h1c000100), '0);
    data_sram_rdata = 32'h80FF1234;
    @(negedge clk);
    checks++;
    if (mem_to_wb_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got %b exp 1", mem_to_wb_valid); end
    checks++;
    if (mem_to_wb_data !== {1'b1, 5'd4, 32'hFFFFFF80, 32'h1c000100}) begin
      errors++; $display("FAIL ldb_data got %h exp %h", mem_to_wb_data, {1'b1, 5'd4, 32'hFFFFFF80, 32'h1c000100});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ld_half;
    enter(mk(LD_HU, 1, 1, 5'd5, 32'h2002, 32'h1c000104), '0);
    data_sram_rdata = 32'h80017FFF;
    @(negedge clk);
    checks++;
    if (mem_to_wb_data[63:32] !== 32'h00008001) begin
      errors++; $display("FAIL ldhu_result got %h exp 00008001", mem_to_wb_data[63:32]);
    end
    @(posedge clk); #1;
    enter(mk(LD_H, 1, 1, 5'd6, 32'h2002, 32'h1c000108), '0);
    data_sram_rdata = 32'h80017FFF;
    @(negedge clk);
    checks++;
    if (mem_to_wb_data[63:32] !== 32'hFFFF8001) begin
      errors++; $display("FAIL ldh_result got %h exp FFFF8001", mem_to_wb_data[63:32]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wb_stall;
    wb_allowin = 1'b0;
    enter(mk(LD_W, 1, 1, 5'd7, 32'h3000, 32'h1c00010c), '0);
    data_sram_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (mem_to_wb_data[63:32] !== 32'hDEADBEEF) begin
        errors++; $display("FAIL stall_result cyc%0d got %h exp DEADBEEF", i, mem_to_wb_data[63:32]);
      end
      checks++;
      if (mem_allowin !== 1'b0) begin errors++; $display("FAIL stall_allowin cyc%0d got %b exp 0", i, mem_allowin); end
      @(posedge clk); #1;
      data_sram_rdata = 32'h0;
    end
    wb_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_to_wb_valid, mem_to_wb_data[63:32]} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL stall_release got v=%b %h exp v=1 DEADBEEF", mem_to_wb_valid, mem_to_wb_data[63:32]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu;
    enter(mk(5'b0, 0, 1, 5'd9, 32'h12345678, 32'h1c000110), '0);
    data_sram_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    checks++;
    if (mem_to_wb_data !== {1'b1, 5'd9, 32'h12345678, 32'h1c000110}) begin
      errors++; $display("FAIL alu_data got %h exp %h", mem_to_wb_data, {1'b1, 5'd9, 32'h12345678, 32'h1c000110});
    end
    checks++;
    if (mem_rf_zip[38:37] !== 2'b01) begin errors++; $display("FAIL alu_zip_flags got %b exp 01", mem_rf_zip[38:37]); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    enter(mk(5'b0, 0, 1, 5'd10, 32'h11, 32'h1c000114), '0);
    ex_to_mem_valid = 1'b1;
    ex_to_mem_data  = mk(5'b0, 0, 1, 5'd11, 32'h22, 32'h1c000118);
    wb_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_to_wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wbv got %b exp 0", mem_to_wb_valid); end
    @(posedge clk); #1;
    wb_flush = 1'b0; ex_to_mem_valid = 1'b0; wb_allowin = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_allowin, mem_to_wb_valid, mem_rf_zip[37]} !== 3'b100) begin
      errors++; $display("FAIL flush_dropped got allow=%b wbv=%b we=%b exp 1 0 0", mem_allowin, mem_to_wb_valid, mem_rf_zip[37]);
    end
    wb_allowin = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exc_reset;
    logic [95:0] x;
    x = {$urandom, $urandom, $urandom};
    x[15] = 1'b1; x[16] = 1'b0; x[81] = 1'b0;
    enter(mk(5'b0, 0, 0, 5'd0, 32'h0, 32'h1c00011c), x);
    @(negedge clk);
    checks++;
    if ({mem_ex, mem_csr_blk} !== 2'b11) begin errors++; $display("FAIL exc_flags got %b%b exp 11", mem_ex, mem_csr_blk); end
    checks++;
    if (mem_to_wb_excep !== x) begin errors++; $display("FAIL exc_bundle got %h exp %h", mem_to_wb_excep, x); end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({mem_to_wb_valid, mem_ex, mem_csr_blk, mem_allowin} !== 4'b0001) begin
      errors++; $display("FAIL async_reset got v=%b ex=%b blk=%b allow=%b exp 0 0 0 1",
                         mem_to_wb_valid, mem_ex, mem_csr_blk, mem_allowin);
    end
    @(posedge clk); #1; resetn = 1'b1;
    enter(mk(LD_W, 1, 1, 5'd3, 32'h8, 32'h1c000120), '0);
    data_sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++;
    if ({mem_to_wb_valid, mem_to_wb_data[63:32]} !== {1'b1, 32'hCAFEF00D}) begin
      errors++; $display("FAIL post_reset_entry got v=%b %h exp v=1 CAFEF00D", mem_to_wb_valid, mem_to_wb_data[63:32]);
    end
    @(posedge clk); #1;
    data_sram_rdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    logic        m_v = 1'b0, m_first = 1'b0;
    logic [75:0] m_d = '0;
    logic [95:0] m_x = '0;
    logic [31:0] m_word = '0, w, res;
    logic [4:0]  op;
    for (int i = 0; i < 400; i++) begin
      op = ($urandom_range(0, 5) == 5) ? 5'b0 : 5'b1 << $urandom_range(0, 4);
      ex_to_mem_valid = $urandom_range(0, 3) != 0;
      ex_to_mem_data  = mk(op, op != 0, $urandom, 5'($urandom), $urandom, $urandom);
      ex_to_mem_excep = {$urandom, $urandom, $urandom};
      wb_allowin      = $urandom_range(0, 9) < 7;
      wb_flush        = $urandom_range(0, 9) == 0;
      data_sram_rdata = $urandom;
      @(negedge clk);
      checks++;
      if (mem_allowin !== (!m_v || wb_allowin)) begin
        errors++; $display("FAIL rnd_allowin cyc%0d got %b exp %b", i, mem_allowin, !m_v || wb_allowin);
      end
      checks++;
      if (mem_to_wb_valid !== (m_v && !wb_flush)) begin
        errors++; $display("FAIL rnd_wbv cyc%0d got %b exp %b", i, mem_to_wb_valid, m_v && !wb_flush);
      end
      if (m_v) begin
        w = m_first ? data_sram_rdata : m_word;
        res = ref_result(m_d, w);
        checks++;
        if (mem_to_wb_data !== {m_d[69:64], res, m_d[31:0]}) begin
          errors++; $display("FAIL rnd_data cyc%0d got %h exp %h", i, mem_to_wb_data, {m_d[69:64], res, m_d[31:0]});
        end
        checks++;
        if (mem_rf_zip !== {m_d[70:64], res}) begin
          errors++; $display("FAIL rnd_zip cyc%0d got %h exp %h", i, mem_rf_zip, {m_d[70:64], res});
        end
        checks++;
        if ({mem_to_wb_excep, mem_ex, mem_csr_blk} !== {m_x, m_x[15] | m_x[16], m_x[15] | m_x[16] | m_x[81]}) begin
          errors++; $display("FAIL rnd_excep cyc%0d got %h %b%b exp %h", i, mem_to_wb_excep, mem_ex, mem_csr_blk, m_x);
        end
      end else begin
        checks++;
        if ({mem_rf_zip[38:37], mem_ex, mem_csr_blk} !== 4'b0) begin
          errors++; $display("FAIL rnd_idle_flags cyc%0d got %b exp 0000", i, {mem_rf_zip[38:37], mem_ex, mem_csr_blk});
        end
      end
      @(posedge clk);
      if (m_v && m_first) begin m_word = data_sram_rdata; m_first = 1'b0; end
      if (wb_flush) m_v = 1'b0;
      else if (!m_v || wb_allowin) begin
        m_v = ex_to_mem_valid;
        if (ex_to_mem_valid) begin m_d = ex_to_mem_data; m_x = ex_to_mem_excep; m_first = 1'b1; end
      end
      #1;
    end
    wb_flush = 1'b0; ex_to_mem_valid = 1'b0; wb_allowin = 1'b1;
  endtask

  initial begin
    test_reset;
    test_ld_b;
    test_ld_half;
    test_wb_stall;
    test_alu;
    test_flush;
    test_exc_reset;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
